// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Fetches one 32-bit instruction per branch-facility address and
//               hands it to instruction identify; stalls the branch facility
//               until the instruction is consumed.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_32b_mode,
    input  logic [0:63]  i_next_instr_addr,
    output logic         o_stall,
    output logic         o_mem_req_valid,
    input  logic         i_mem_req_ready,
    output logic [0:63]  o_mem_req_addr,
    input  logic         i_mem_rsp_valid,
    input  logic [0:31]  i_mem_rsp_data,
    input  logic         i_mem_rsp_err,
    output logic [0:31]  o_instr,
    output logic [0:63]  o_instr_addr,
    output logic         o_instr_valid,
    input  logic         i_instr_ready,
    output logic [0:2]   o_err,
    output logic         o_halted,
    output logic         o_err_spurious_rsp
);

    localparam logic [1:0]  c_st_req       = 2'd0;
    localparam logic [1:0]  c_st_wait      = 2'd1;
    localparam logic [1:0]  c_st_out       = 2'd2;
    localparam logic [1:0]  c_st_halt      = 2'd3;
    localparam logic [15:0] c_timeout_last = 16'(TIMEOUT - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [0:63] r_fetch_addr;
    logic [0:31] r_instr;
    logic [0:63] r_instr_addr;
    logic [0:2]  r_err;
    logic        r_spurious;
    logic [15:0] r_cnt;

    logic        w_misaligned;
    logic        w_req_fire;
    logic        w_timeout;
    logic        w_instr_fire;
    logic [0:63] w_next_fetch;

    assign w_misaligned = (r_fetch_addr[62:63] != 2'b00);
    assign w_timeout    = (r_cnt == c_timeout_last);
    assign w_instr_fire = (r_state == c_st_out) && i_instr_ready;
    assign w_req_fire   = o_mem_req_valid && i_mem_req_ready;
    assign w_next_fetch = {(i_32b_mode ? 32'h0 : i_next_instr_addr[0:31]),
                           i_next_instr_addr[32:63]};

    // Request is suppressed while reset is asserted so memory never sees a
    // request that the reset is about to abandon.
    assign o_mem_req_valid    = !i_rst && (r_state == c_st_req) && !w_misaligned;
    assign o_mem_req_addr     = r_fetch_addr;
    assign o_instr            = r_instr;
    assign o_instr_addr       = r_instr_addr;
    assign o_instr_valid      = (r_state == c_st_out);
    assign o_stall            = !w_instr_fire;
    assign o_err              = r_err;
    assign o_halted           = (r_state == c_st_halt);
    assign o_err_spurious_rsp = r_spurious;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_req: begin
                if (w_misaligned)    w_state_next = c_st_halt;
                else if (w_req_fire) w_state_next = c_st_wait;
            end
            c_st_wait: begin
                // A response beats a simultaneous timeout.
                if (i_mem_rsp_valid)  w_state_next = i_mem_rsp_err ? c_st_halt : c_st_out;
                else if (w_timeout)   w_state_next = c_st_halt;
            end
            c_st_out: begin
                if (i_instr_ready) w_state_next = c_st_req;
            end
            c_st_halt: w_state_next = c_st_halt;
            default:   w_state_next = c_st_halt;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= c_st_req;
            r_fetch_addr <= '0;
            r_instr      <= '0;
            r_instr_addr <= '0;
            r_err        <= '0;
            r_spurious   <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                c_st_req: begin
                    if (w_misaligned)    r_err[0] <= 1'b1;
                    else if (w_req_fire) r_cnt    <= '0;
                end
                c_st_wait: begin
                    r_cnt <= r_cnt + 16'd1;
                    if (i_mem_rsp_valid) begin
                        if (i_mem_rsp_err) begin
                            r_err[1] <= 1'b1;
                        end else begin
                            r_instr      <= i_mem_rsp_data;
                            r_instr_addr <= r_fetch_addr;
                        end
                    end else if (w_timeout) begin
                        r_err[2] <= 1'b1;
                    end
                end
                c_st_out: begin
                    if (i_instr_ready) r_fetch_addr <= w_next_fetch;
                end
                default: ;
            endcase
            // Only WAIT can legitimately receive a response.
            if (i_mem_rsp_valid && (r_state != c_st_wait)) r_spurious <= 1'b1;
        end
    end

endmodule
`default_nettype wire
